// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward selects, memory-wait FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } hz_state_t;

  localparam int REG_ZERO = 0;

  // Performance counters hold at all-ones rather than wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// EX-stage forward select for one source operand; purely combinational, M result beats W result.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rd_m_i,
  input  logic [REG_W-1:0] rd_w_i,
  input  logic             reg_write_m_i,
  input  logic             reg_write_w_i,
  output fwd_sel_t         fwd_o
);

  logic rs_nonzero;

  // x0 is hardwired, so a write to it must never be forwarded.
  assign rs_nonzero = (rs_i != REG_W'(REG_ZERO));

  always_comb begin
    fwd_o = FWD_RF;
    if (rs_nonzero && reg_write_m_i && (rd_m_i == rs_i)) begin
      fwd_o = FWD_M;
    end else if (rs_nonzero && reg_write_w_i && (rd_w_i == rs_i)) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: combinational stall/flush/forward with a registered memory-wait FSM and sticky timeout.
// Optional HAZARD_PERF_CNT_EN adds saturating lw-stall and mem-stall cycle counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [REG_W-1:0] rs1D_i,
  input  logic [REG_W-1:0] rs2D_i,
  input  logic [REG_W-1:0] rs1E_i,
  input  logic [REG_W-1:0] rs2E_i,
  input  logic [REG_W-1:0] rdE_i,
  input  logic [REG_W-1:0] rdM_i,
  input  logic [REG_W-1:0] rdW_i,
  input  logic             load_E_i,
  input  logic             reg_writeM_i,
  input  logic             reg_writeW_i,
  input  logic             pc_srcE_i,
  input  logic             mem_reqM_i,
  input  logic             mem_readyM_i,
  output logic [1:0]       forwardAE_o,
  output logic [1:0]       forwardBE_o,
  output logic             stallF_o,
  output logic             stallD_o,
  output logic             stallE_o,
  output logic             stallM_o,
  output logic             flushD_o,
  output logic             flushE_o,
  output logic             flushW_o,
  output logic             mem_err_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      lw_stall_cnt_o,
  output logic [31:0]      mem_stall_cnt_o
`endif
);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  fwd_sel_t         fwd_a, fwd_b;
  logic             lw_stall;
  logic             mem_stall;

  hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .rs_i          (rs1E_i),
    .rd_m_i        (rdM_i),
    .rd_w_i        (rdW_i),
    .reg_write_m_i (reg_writeM_i),
    .reg_write_w_i (reg_writeW_i),
    .fwd_o         (fwd_a)
  );

  hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .rs_i          (rs2E_i),
    .rd_m_i        (rdM_i),
    .rd_w_i        (rdW_i),
    .reg_write_m_i (reg_writeM_i),
    .reg_write_w_i (reg_writeW_i),
    .fwd_o         (fwd_b)
  );

  assign lw_stall = load_E_i && (rdE_i != REG_W'(REG_ZERO)) &&
                    ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));

  // The ready cycle itself never stalls, so release costs no extra cycle.
  assign mem_stall = ((state_q == IDLE) && mem_reqM_i && !mem_readyM_i) ||
                     ((state_q == MEM_WAIT) && !mem_readyM_i) ||
                     (state_q == ERR);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      IDLE: begin
        if (mem_reqM_i && !mem_readyM_i) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_readyM_i) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d   = ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ERR: begin
        mem_err_d = 1'b1;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Outputs are gated by reset so the pipeline is released the instant reset rises.
  always_comb begin
    forwardAE_o = FWD_RF;
    forwardBE_o = FWD_RF;
    stallF_o    = 1'b0;
    stallD_o    = 1'b0;
    stallE_o    = 1'b0;
    stallM_o    = 1'b0;
    flushD_o    = 1'b0;
    flushE_o    = 1'b0;
    flushW_o    = 1'b0;
    if (!reset_i) begin
      forwardAE_o = fwd_a;
      forwardBE_o = fwd_b;
      if (mem_stall) begin
        // E stays frozen, so a pending branch or load-use flush re-asserts after release.
        stallF_o = 1'b1;
        stallD_o = 1'b1;
        stallE_o = 1'b1;
        stallM_o = 1'b1;
        flushW_o = 1'b1;
      end else begin
        stallF_o = lw_stall;
        stallD_o = lw_stall;
        flushE_o = lw_stall | pc_srcE_i;
        flushD_o = pc_srcE_i;
      end
    end
  end

  assign mem_err_o = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lw_cnt_q, lw_cnt_d;
  logic [31:0] mem_cnt_q, mem_cnt_d;

  always_comb begin
    lw_cnt_d  = lw_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if (mem_stall) begin
      mem_cnt_d = sat_inc32(mem_cnt_q);
    end else if (lw_stall) begin
      lw_cnt_d = sat_inc32(lw_cnt_q);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lw_cnt_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      lw_cnt_q  <= lw_cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  assign lw_stall_cnt_o  = lw_cnt_q;
  assign mem_stall_cnt_o = mem_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: per-cycle expectations from a behavioural model, checked at negedge.
// Counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_unit;

  localparam int REG_W       = 5;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 5;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [REG_W-1:0] rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, rdM_i, rdW_i;
  logic             load_E_i, reg_writeM_i, reg_writeW_i, pc_srcE_i;
  logic             mem_reqM_i, mem_readyM_i;
  logic [1:0]       forwardAE_o, forwardBE_o;
  logic             stallF_o, stallD_o, stallE_o, stallM_o;
  logic             flushD_o, flushE_o, flushW_o, mem_err_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]      lw_stall_cnt_o, mem_stall_cnt_o;
`endif

  hazard_unit #(.REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .rs1D_i       (rs1D_i),
    .rs2D_i       (rs2D_i),
    .rs1E_i       (rs1E_i),
    .rs2E_i       (rs2E_i),
    .rdE_i        (rdE_i),
    .rdM_i        (rdM_i),
    .rdW_i        (rdW_i),
    .load_E_i     (load_E_i),
    .reg_writeM_i (reg_writeM_i),
    .reg_writeW_i (reg_writeW_i),
    .pc_srcE_i    (pc_srcE_i),
    .mem_reqM_i   (mem_reqM_i),
    .mem_readyM_i (mem_readyM_i),
    .forwardAE_o  (forwardAE_o),
    .forwardBE_o  (forwardBE_o),
    .stallF_o     (stallF_o),
    .stallD_o     (stallD_o),
    .stallE_o     (stallE_o),
    .stallM_o     (stallM_o),
    .flushD_o     (flushD_o),
    .flushE_o     (flushE_o),
    .flushW_o     (flushW_o),
    .mem_err_o    (mem_err_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .lw_stall_cnt_o  (lw_stall_cnt_o),
    .mem_stall_cnt_o (mem_stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [REG_W-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic             loadE, wm, ww, pc, req, rdy;
  } stim_t;

  typedef logic [12:0] obs_t;

  obs_t obs;
  assign obs = {forwardAE_o, forwardBE_o, stallF_o, stallD_o, stallE_o, stallM_o,
                flushD_o, flushE_o, flushW_o, mem_err_o};

  obs_t sb_q[$];
  int   id_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: counts consecutive stalled cycles of the current access.
  bit m_err;
  bit m_in_wait;
  int m_stall_n;
  int m_lw_n;
  int m_mem_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s.rs1D = '0; s.rs2D = '0; s.rs1E = '0; s.rs2E = '0;
    s.rdE = '0; s.rdM = '0; s.rdW = '0;
    s.loadE = 1'b0; s.wm = 1'b0; s.ww = 1'b0; s.pc = 1'b0; s.req = 1'b0; s.rdy = 1'b0;
    return s;
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [REG_W-1:0] rs, input stim_t s);
    if (rs == '0) return 2'b00;
    if (s.wm && s.rdM == rs) return 2'b10;
    if (s.ww && s.rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic apply(input stim_t s);
    rs1D_i = s.rs1D; rs2D_i = s.rs2D; rs1E_i = s.rs1E; rs2E_i = s.rs2E;
    rdE_i = s.rdE; rdM_i = s.rdM; rdW_i = s.rdW;
    load_E_i = s.loadE; reg_writeM_i = s.wm; reg_writeW_i = s.ww;
    pc_srcE_i = s.pc; mem_reqM_i = s.req; mem_readyM_i = s.rdy;
  endtask

  task automatic model_reset();
    m_err = 1'b0; m_in_wait = 1'b0; m_stall_n = 0; m_lw_n = 0; m_mem_n = 0;
  endtask

  task automatic drive_cycle(input stim_t s);
    logic [1:0] fa, fb;
    bit lw, ms;
    obs_t e;
    apply(s);
    fa = fwd_ref(s.rs1E, s);
    fb = fwd_ref(s.rs2E, s);
    lw = s.loadE && (s.rdE != '0) && (s.rdE == s.rs1D || s.rdE == s.rs2D);
    ms = m_err || ((m_in_wait || s.req) && !s.rdy);
    if (ms) e = {fa, fb, 4'b1111, 1'b0, 1'b0, 1'b1, m_err};
    else    e = {fa, fb, lw, lw, 1'b0, 1'b0, s.pc, lw | s.pc, 1'b0, m_err};
    sb_q.push_back(e);
    id_q.push_back(cyc);
    cyc++;
    if (ms) begin
      m_mem_n++;
      if (!m_err) begin
        m_stall_n++;
        m_in_wait = 1'b1;
        if (m_stall_n >= MEM_TIMEOUT) m_err = 1'b1;
      end
    end else begin
      m_in_wait = 1'b0;
      m_stall_n = 0;
      if (lw) m_lw_n++;
    end
    @(posedge clk_i); #1;
  endtask

  // Reset is raised with a stalling request on the inputs to show outputs are forced low.
  task automatic do_reset();
    stim_t s;
    s = idle_stim();
    s.req = 1'b1; s.rs1E = 5'd3; s.rdM = 5'd3; s.wm = 1'b1; s.pc = 1'b1;
    apply(s);
    reset_i = 1'b1;
    #1;
    check("reset outputs", 32'(obs), 32'd0);
    @(posedge clk_i); #1;
    check("reset held outputs", 32'(obs), 32'd0);
    apply(idle_stim());
    reset_i = 1'b0;
    model_reset();
  endtask

  always @(negedge clk_i) begin
    if (sb_q.size() != 0) begin
      obs_t e;
      int id;
      e  = sb_q.pop_front();
      id = id_q.pop_front();
      check($sformatf("cycle %0d outputs", id), 32'(obs), 32'(e));
    end
  end

  initial begin
    stim_t s;
    model_reset();
    do_reset();

    // Forwarding: M wins over W; x0 never forwards.
    s = idle_stim(); s.rs1E = 5'd5; s.rdM = 5'd5; s.wm = 1'b1; s.rdW = 5'd5; s.ww = 1'b1;
    drive_cycle(s);
    s.rs1E = 5'd0;
    drive_cycle(s);
    s = idle_stim(); s.rs2E = 5'd9; s.rdW = 5'd9; s.ww = 1'b1; s.rdM = 5'd4; s.wm = 1'b1;
    drive_cycle(s);

    // Load-use, then the same with rdE = x0, then a second load-use via rs1D.
    s = idle_stim(); s.loadE = 1'b1; s.rdE = 5'd7; s.rs2D = 5'd7;
    drive_cycle(s);
    s.rdE = 5'd0; s.rs2D = 5'd0;
    drive_cycle(s);
    s = idle_stim(); s.loadE = 1'b1; s.rdE = 5'd12; s.rs1D = 5'd12; s.pc = 1'b1;
    drive_cycle(s);

    // Branch alone.
    s = idle_stim(); s.pc = 1'b1;
    drive_cycle(s);

    // Three wait cycles with a pending branch, released on ready.
    s = idle_stim(); s.req = 1'b1; s.pc = 1'b1;
    repeat (3) drive_cycle(s);
    s.rdy = 1'b1;
    drive_cycle(s);
    s = idle_stim(); s.rdy = 1'b1;
    drive_cycle(s);
    drive_cycle(idle_stim());
`ifdef HAZARD_PERF_CNT_EN
    check("lw_stall_cnt after directed", lw_stall_cnt_o, 32'(m_lw_n));
    check("mem_stall_cnt after directed", mem_stall_cnt_o, 32'(m_mem_n));
`endif

    // Timeout: ready never comes, then arrives too late.
    do_reset();
    s = idle_stim(); s.req = 1'b1;
    repeat (MEM_TIMEOUT + 2) drive_cycle(s);
    s.rdy = 1'b1;
    repeat (2) drive_cycle(s);
    s.rdy = 1'b0;
    apply(s);
    #6;
    check("err before async reset", 32'(mem_err_o), 32'd1);
    check("stallF before async reset", 32'(stallF_o), 32'd1);
    reset_i = 1'b1;
    #1;
    check("async reset clears err", 32'(mem_err_o), 32'd0);
    check("async reset clears stalls", 32'(obs), 32'd0);
    @(posedge clk_i); #1;
    apply(idle_stim());
    reset_i = 1'b0;
    model_reset();
    drive_cycle(idle_stim());

    // Randomized traffic with small register indices to force matches.
    for (int i = 0; i < 400; i++) begin
      s.rs1D  = 5'($urandom_range(0, 3));
      s.rs2D  = 5'($urandom_range(0, 3));
      s.rs1E  = 5'($urandom_range(0, 3));
      s.rs2E  = 5'($urandom_range(0, 3));
      s.rdE   = 5'($urandom_range(0, 3));
      s.rdM   = 5'($urandom_range(0, 3));
      s.rdW   = 5'($urandom_range(0, 3));
      s.loadE = ($urandom_range(0, 2) == 0);
      s.wm    = ($urandom_range(0, 1) == 0);
      s.ww    = ($urandom_range(0, 1) == 0);
      s.pc    = ($urandom_range(0, 4) == 0);
      s.req   = ($urandom_range(0, 3) == 0);
      s.rdy   = ($urandom_range(0, 4) < 3);
      drive_cycle(s);
    end
    apply(idle_stim());
`ifdef HAZARD_PERF_CNT_EN
    check("lw_stall_cnt after random", lw_stall_cnt_o, 32'(m_lw_n));
    check("mem_stall_cnt after random", mem_stall_cnt_o, 32'(m_mem_n));
`endif

    for (int k = 0; k < 5 && sb_q.size() != 0; k++) @(negedge clk_i);
    #1;
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage CPU.
- Produces the active-high stall/flush controls that the stage registers consume (stall=1 holds, flush=1 clears), plus EX-stage forwarding selects.
- Adds a registered memory-wait FSM with a timeout for multi-cycle data-memory accesses in M.

Parameters:
REG_W, 5, register-address width
MEM_TIMEOUT, 16, max MEM_WAIT cycles before error (>=2)
CNT_W, 5, wait-counter width (2^CNT_W > MEM_TIMEOUT)

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  asynchronous, active-high reset
rs1D_i, rs2D_i  in  REG_W  source regs in D
rs1E_i, rs2E_i  in  REG_W  source regs in E
rdE_i, rdM_i, rdW_i  in  REG_W  destination regs in E/M/W
load_E_i  in  1  instruction in E is a load
reg_writeM_i, reg_writeW_i  in  1  M/W will write rd
pc_srcE_i  in  1  taken branch/jump resolved in E
mem_reqM_i  in  1  M issues a data-memory access
mem_readyM_i  in  1  data memory completes the access this cycle
forwardAE_o, forwardBE_o  out  2  00=regfile, 01=W result, 10=M ALU result
stallF_o, stallD_o, stallE_o, stallM_o  out  1  hold stage register
flushD_o, flushE_o, flushW_o  out  1  clear stage register to a bubble
mem_err_o  out  1  sticky timeout error

Behaviour:
- Reset (async, while reset_i=1): state=IDLE, wait_cnt=0, mem_err_o=0. All stall/flush outputs=0; forward=00.
- Forwarding, combinational, per source:
  - 10 if reg_writeM & rdM==rsE & rsE!=0.
  - else 01 if reg_writeW & rdW==rsE & rsE!=0.
  - else 00.
  - M has priority over W.
- lw_stall = load_E & rdE!=0 & (rdE==rs1D | rdE==rs2D).
- mem_stall = (state==IDLE & mem_reqM & !mem_readyM) | (state==MEM_WAIT & !mem_readyM) | state==ERR.
- FSM states IDLE, MEM_WAIT, ERR:
  - IDLE -> MEM_WAIT when mem_reqM & !mem_readyM; wait_cnt<=1.
  - MEM_WAIT: mem_readyM -> IDLE, cnt<=0, with stall released in the same cycle (zero-latency release). Else if wait_cnt==MEM_TIMEOUT-1 -> ERR, mem_err_o<=1. Else cnt++.
  - ERR: sticky until reset. Pipeline fully frozen.
- Output priority:
  - 1. mem_stall: stallF/D/E/M=1, flushW=1, flushD=flushE=0. Branch and lw flushes are suppressed, not lost, because E is frozen and pc_srcE persists.
  - 2. otherwise: stallF=stallD=lw_stall; flushE = lw_stall | pc_srcE; flushD = pc_srcE; stallE=stallM=flushW=0.
- Simultaneous lw_stall and pc_srcE (no mem_stall): flushD=1, flushE=1, stallF=stallD=1.
- Reset mid-wait: immediate return to IDLE; all outputs deassert asynchronously.
- mem_readyM while not requesting: ignored.

Optional Feature:
- HAZARD_PERF_CNT_EN:
  - Defined: adds outputs lw_stall_cnt_o[31:0] and mem_stall_cnt_o[31:0]. These are saturating counters incremented on each cycle with lw_stall (no mem_stall) or mem_stall respectively. Reset to 0.
  - Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg:
  - typedef enum logic[1:0] fwd_sel_t {FWD_RF=00, FWD_W=01, FWD_M=10}.
  - typedef enum logic[1:0] hz_state_t {IDLE, MEM_WAIT, ERR}.
  - localparam REG_ZERO=0.
- One sub-module, hazard_fwd_sel: combinational forward-select for a single source operand, instantiated twice (A, B).

Test Plan:
- Forward: rs1E=5, rdM=5, reg_writeM=1, rdW=5, reg_writeW=1 -> forwardAE=10. Same case with rs1E=0 -> 00.
- Load-use: load_E=1, rdE=7, rs2D=7 -> stallF=stallD=1, flushE=1, flushD=0 for one cycle. Same case with rdE=0 -> no stall.
- Branch: pc_srcE=1, no other hazards -> flushD=flushE=1, no stalls.
- Memory wait: mem_reqM=1, mem_readyM=0 for 3 cycles then 1 -> stallF/D/E/M=1 and flushW=1 for exactly 3 cycles. Release in the ready cycle; state back to IDLE; a coincident pc_srcE flush appears only in the ready cycle.
- Timeout: MEM_TIMEOUT=16, mem_readyM held 0 -> mem_err_o=1 after the 16th stall cycle. Stalls persist indefinitely; a later mem_readyM=1 has no effect. Asserting reset_i mid-cycle clears mem_err_o and all stalls asynchronously.
- Perf (HAZARD_PERF_CNT_EN defined): 2 lw stalls + 3 mem-wait cycles -> lw_stall_cnt_o=2, mem_stall_cnt_o=3.
